// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   // Which requester owns the memory response that arrives next cycle.
   typedef enum logic [1:0] {
      NONE    = 2'd0,
      IMEM    = 2'd1,
      DMEM_RD = 2'd2,
      DMEM_WR = 2'd3
   } owner_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: imem vs dmem. The pointer moves only on
// conflicts so the losing port wins the next conflict.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_imem,
   input  logic       req_dmem,
   output logic [1:0] grant,      // bit 0 = imem, bit 1 = dmem
   output logic       conflict
);

   logic rr_dmem_first;

   // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
   always_comb begin
      grant    = 2'b00;
      conflict = req_imem & req_dmem;
      if (conflict)
         grant = rr_dmem_first ? 2'b10 : 2'b01;
      else if (req_imem)
         grant = 2'b01;
      else if (req_dmem)
         grant = 2'b10;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_dmem_first <= 1'b1;
      else if (conflict)
         rr_dmem_first <= grant[0];   // imem just won, so dmem goes first next time
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency memory between the instruction
// and data ports; the owner register steers each response back to its issuer.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              imemreq_val,
   output logic              imemreq_rdy,
   input  logic [ADDR_W-1:0] imemreq_addr,
   output logic              imemresp_val,
   output logic [DATA_W-1:0] imemresp_data,

   input  logic              dmemreq_val,
   output logic              dmemreq_rdy,
   input  logic              dmemreq_type,
   input  logic [ADDR_W-1:0] dmemreq_addr,
   input  logic [DATA_W-1:0] dmemreq_wdata,
   output logic              dmemresp_val,
   output logic [DATA_W-1:0] dmemresp_rdata,

   output logic              memreq_val,
   output logic              memreq_type,
   output logic [ADDR_W-1:0] memreq_addr,
   output logic [DATA_W-1:0] memreq_wdata,
   input  logic [DATA_W-1:0] memresp_rdata,

   output logic [CNT_W-1:0]  conflict_count
);

   logic       imem_req;
   logic       dmem_req;
   logic [1:0] grant;
   logic       conflict;
   owner_t     owner;
   owner_t     owner_next;

   // Requests are masked while reset is held so no port sees rdy during reset.
   assign imem_req = imemreq_val & rst;
   assign dmem_req = dmemreq_val & rst;

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (rst),
      .req_imem (imem_req),
      .req_dmem (dmem_req),
      .grant    (grant),
      .conflict (conflict)
   );

   assign imemreq_rdy = grant[0];
   assign dmemreq_rdy = grant[1];

   always_comb begin
      memreq_val   = 1'b0;
      memreq_type  = MEM_READ;
      memreq_addr  = '0;
      memreq_wdata = '0;
      owner_next   = NONE;
      if (grant[0]) begin
         memreq_val  = 1'b1;
         memreq_addr = imemreq_addr;
         owner_next  = IMEM;
      end else if (grant[1]) begin
         memreq_val   = 1'b1;
         memreq_type  = dmemreq_type;
         memreq_addr  = dmemreq_addr;
         memreq_wdata = dmemreq_wdata;
         owner_next   = (dmemreq_type == MEM_WRITE) ? DMEM_WR : DMEM_RD;
      end
   end

   // NOTE: asynchronous reset clears the owner at once, dropping any in-flight response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         owner <= NONE;
      else
         owner <= owner_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         conflict_count <= '0;
      else if (conflict && (conflict_count != {CNT_W{1'b1}}))
         conflict_count <= conflict_count + CNT_W'(1);
   end

   // Response steering; the port that does not own the response reads zero.
   assign imemresp_val   = (owner == IMEM);
   assign imemresp_data  = (owner == IMEM) ? memresp_rdata : '0;
   assign dmemresp_val   = (owner == DMEM_RD) || (owner == DMEM_WR);
   assign dmemresp_rdata = (owner == DMEM_RD) ? memresp_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against
// a port-level reference model and a behavioural memory.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          imemreq_val;
   logic          imemreq_rdy;
   logic [AW-1:0] imemreq_addr;
   logic          imemresp_val;
   logic [DW-1:0] imemresp_data;
   logic          dmemreq_val;
   logic          dmemreq_rdy;
   logic          dmemreq_type;
   logic [AW-1:0] dmemreq_addr;
   logic [DW-1:0] dmemreq_wdata;
   logic          dmemresp_val;
   logic [DW-1:0] dmemresp_rdata;
   logic          memreq_val;
   logic          memreq_type;
   logic [AW-1:0] memreq_addr;
   logic [DW-1:0] memreq_wdata;
   logic [DW-1:0] memresp_rdata;
   logic [CW-1:0] conflict_count;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .imemreq_val    (imemreq_val),
      .imemreq_rdy    (imemreq_rdy),
      .imemreq_addr   (imemreq_addr),
      .imemresp_val   (imemresp_val),
      .imemresp_data  (imemresp_data),
      .dmemreq_val    (dmemreq_val),
      .dmemreq_rdy    (dmemreq_rdy),
      .dmemreq_type   (dmemreq_type),
      .dmemreq_addr   (dmemreq_addr),
      .dmemreq_wdata  (dmemreq_wdata),
      .dmemresp_val   (dmemresp_val),
      .dmemresp_rdata (dmemresp_rdata),
      .memreq_val     (memreq_val),
      .memreq_type    (memreq_type),
      .memreq_addr    (memreq_addr),
      .memreq_wdata   (memreq_wdata),
      .memresp_rdata  (memresp_rdata),
      .conflict_count (conflict_count)
   );

   int checks = 0;
   int errors = 0;

   // env_mem is the memory the DUT talks to; ref_mem is the model's view.
   bit [31:0] env_mem [bit [31:0]];
   bit [31:0] ref_mem [bit [31:0]];

   typedef enum {P_NONE, P_IMEM, P_DMEM} port_e;
   bit    dmem_wins_next;
   int    conflicts;
   port_e exp_port;
   bit [31:0] exp_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] ref_rd(input bit [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic bit [31:0] env_rd(input bit [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : 32'h0;
   endfunction

   task automatic preload(input bit [31:0] a, input bit [31:0] d);
      env_mem[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic model_reset();
      dmem_wins_next = 1'b1;
      conflicts      = 0;
      exp_port       = P_NONE;
      exp_data       = 32'h0;
   endtask

   // Held reset with both ports requesting: nothing may be granted or answered.
   task automatic reset_phase(input int cycles);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < cycles; i++) begin
         imemreq_val  = 1'b1;
         dmemreq_val  = 1'b1;
         imemreq_addr = $urandom;
         dmemreq_addr = $urandom;
         memresp_rdata = $urandom;
         #1;
         check("rst_irdy", imemreq_rdy, 1'b0);
         check("rst_drdy", dmemreq_rdy, 1'b0);
         check("rst_memval", memreq_val, 1'b0);
         check("rst_iresp", imemresp_val, 1'b0);
         check("rst_dresp", dmemresp_val, 1'b0);
         check("rst_count", conflict_count, 0);
         @(negedge clk);
      end
      imemreq_val = 1'b0;
      dmemreq_val = 1'b0;
      rst = 1'b1;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input bit iv, input bit [31:0] ia, input bit dv,
                       input bit dt, input bit [31:0] da, input bit [31:0] dw);
      port_e     win;
      bit [31:0] env_next;
      imemreq_val   = iv;
      imemreq_addr  = ia;
      dmemreq_val   = dv;
      dmemreq_type  = dt;
      dmemreq_addr  = da;
      dmemreq_wdata = dw;
      #1;
      // Response for whatever was accepted last cycle.
      check("imemresp_val", imemresp_val, exp_port == P_IMEM);
      check("imemresp_data", imemresp_data, (exp_port == P_IMEM) ? exp_data : 32'h0);
      check("dmemresp_val", dmemresp_val, exp_port == P_DMEM);
      check("dmemresp_rdata", dmemresp_rdata, (exp_port == P_DMEM) ? exp_data : 32'h0);

      if (iv && dv)  win = dmem_wins_next ? P_DMEM : P_IMEM;
      else if (iv)   win = P_IMEM;
      else if (dv)   win = P_DMEM;
      else           win = P_NONE;

      check("imemreq_rdy", imemreq_rdy, win == P_IMEM);
      check("dmemreq_rdy", dmemreq_rdy, win == P_DMEM);
      check("memreq_val", memreq_val, win != P_NONE);
      if (win == P_IMEM) begin
         check("memreq_addr_i", memreq_addr, ia);
         check("memreq_type_i", memreq_type, 1'b0);
         check("memreq_wdata_i", memreq_wdata, 32'h0);
      end else if (win == P_DMEM) begin
         check("memreq_addr_d", memreq_addr, da);
         check("memreq_type_d", memreq_type, dt);
         if (dt) check("memreq_wdata_d", memreq_wdata, dw);
      end

      if (iv && dv) begin
         conflicts++;
         dmem_wins_next = (win == P_IMEM);
      end
      exp_port = win;
      exp_data = 32'h0;
      if (win == P_IMEM)
         exp_data = ref_rd(ia);
      else if (win == P_DMEM) begin
         if (dt) ref_mem[da] = dw;
         else    exp_data = ref_rd(da);
      end

      // Behavioural memory: reads return data next cycle, otherwise garbage.
      env_next = $urandom;
      if (memreq_val === 1'b1) begin
         if (memreq_type === 1'b1) env_mem[memreq_addr] = memreq_wdata;
         else                      env_next = env_rd(memreq_addr);
      end

      @(posedge clk);
      #1;
      memresp_rdata = env_next;
      check("conflict_count", conflict_count, (conflicts > 15) ? 15 : conflicts);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      imemreq_val = 1'b0; imemreq_addr = '0;
      dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
      memresp_rdata = '0;
      model_reset();
      @(negedge clk);
      reset_phase(2);

      // Lone imem read.
      preload(32'h200, 32'hdeadbeef);
      step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("lone_imem_val", imemresp_val, 1'b1);
      check("lone_imem_data", imemresp_data, 32'hdeadbeef);
      check("lone_dmem_val", dmemresp_val, 1'b0);
      idle();

      // Conflict alternation right after reset: D, I, D, I.
      reset_phase(1);
      preload(32'h40, 32'h1111_0000);
      preload(32'h80, 32'h2222_0000);
      for (int i = 0; i < 4; i++) begin
         #1;
         step(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
      end
      check("alt_count", conflict_count, 4);
      idle();

      // Write then read.
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h12345678);
      #1;
      check("wr_ack_val", dmemresp_val, 1'b1);
      check("wr_ack_data", dmemresp_rdata, 32'h0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0);
      #1;
      check("rd_after_wr", dmemresp_rdata, 32'h12345678);
      idle();

      // Back-to-back imem reads with no bubbles.
      preload(32'h0, 32'ha0a0_0000);
      preload(32'h4, 32'ha0a0_0004);
      preload(32'h8, 32'ha0a0_0008);
      for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("b2b_last_val", imemresp_val, 1'b1);
      check("b2b_last_data", imemresp_data, 32'ha0a0_0008);
      idle();

      // Counter saturation.
      for (int i = 0; i < 20; i++)
         step(1'b1, 32'h4, 1'b1, 1'(i % 2), 32'h8, $urandom);
      check("sat_count", conflict_count, 4'hf);
      idle();

      // Reset mid-flight: dmem read accepted, reset asserted while its response is out.
      reset_phase(1);
      step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
      #1;
      check("mid_resp_before", dmemresp_val, 1'b1);
      rst = 1'b0;
      #1;
      check("mid_resp_dropped", dmemresp_val, 1'b0);
      check("mid_count_zero", conflict_count, 0);
      @(negedge clk);
      reset_phase(1);
      idle();
      idle();
      step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      check("mid_dmem_first", conflicts, 1);

      // Random traffic against the reference model.
      reset_phase(1);
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported, fixed-1-cycle-latency memory between the processor's instruction port and data port. It sits between `Proc` and a single-ported memory model or SRAM. Per-port val/rdy handshakes stall whichever port loses a conflict. Arbitration is round-robin on conflicts. A one-entry owner register routes each memory response back to the port that issued it.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: data width.
- `CNT_W`, default 16: width of the conflict counter.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `imemreq_val`  in  1  instruction read request valid.
- `imemreq_rdy`  out  1  instruction request accepted this cycle.
- `imemreq_addr`  in  ADDR_W  instruction address.
- `imemresp_val`  out  1  instruction response valid.
- `imemresp_data`  out  DATA_W  instruction read data.
- `dmemreq_val`  in  1  data request valid.
- `dmemreq_rdy`  out  1  data request accepted this cycle.
- `dmemreq_type`  in  1  0 = read, 1 = write.
- `dmemreq_addr`  in  ADDR_W  data address.
- `dmemreq_wdata`  in  DATA_W  write data.
- `dmemresp_val`  out  1  data response valid; also the write acknowledge.
- `dmemresp_rdata`  out  DATA_W  read data; 0 for writes.
- `memreq_val`  out  1  request to the shared memory.
- `memreq_type`  out  1  0 = read, 1 = write.
- `memreq_addr`  out  ADDR_W  shared memory address.
- `memreq_wdata`  out  DATA_W  shared memory write data.
- `memresp_rdata`  in  DATA_W  read data, valid exactly one cycle after the request.
- `conflict_count`  out  CNT_W  saturating count of cycles in which both ports requested.

## Operation
- **Grant:**
  - If only one port has val, that port is granted.
  - If both have val, the port selected by the round-robin pointer `rr_dmem_first` is granted.
  - If neither has val, nothing is granted and `memreq_val` = 0.
- **Ready outputs:** `*req_rdy` is combinational and equals the grant for that port. A granted request is accepted in the same cycle.
- **Memory request:** `memreq_*` is a combinational mux of the winning port. An imem winner forces `memreq_type` = 0 and `memreq_wdata` = 0.
- **Round-robin pointer:** updates only on conflict cycles. After a conflict, the pointer favours the loser, so that port wins the next conflict. There is no starvation; under continuous conflict the ports alternate grants strictly.
- **Owner register:** holds NONE, IMEM, DMEM_RD or DMEM_WR. It is loaded every cycle from the grant, or NONE if there is no grant.
- **Responses, one cycle after acceptance:**
  - Owner IMEM: `imemresp_val` = 1, `imemresp_data` = `memresp_rdata`.
  - Owner DMEM_RD: `dmemresp_val` = 1, `dmemresp_rdata` = `memresp_rdata`.
  - Owner DMEM_WR: `dmemresp_val` = 1, `dmemresp_rdata` = 0.
  - There is no response backpressure; the requester must sink the response.
  - The non-owning port's `*resp_data` output is 0.
- **Conflict counter:** increments by 1 on each cycle where both vals are 1. It saturates at all-ones and does not wrap.
- **Reset (`rst` = 0), asynchronous, also mid-operation:**
  - Owner = NONE.
  - `rr_dmem_first` = 1.
  - `conflict_count` = 0.
  - Both `*resp_val` = 0 and both `*req_rdy` = 0; `memreq_val` = 0.
  - Any in-flight response is dropped; no response appears after reset is released.

## Timing
- **Request path:** combinational val → rdy / `memreq` path. Zero added request latency.
- **Response latency:** exactly 1 cycle after acceptance.
- **Throughput:** one access per cycle total. Back-to-back accepts from the same port are allowed with no bubbles.
- **Simultaneous events:** a response for cycle N and a new grant in cycle N+1 coexist. The owner register holds the new grant while the response for cycle N is presented from the previous owner value, registered at edge N→N+1.
- **Reset release:** the first grant can occur in the first cycle with `rst` = 1.

## Structure
- **Package `mem_arb_pkg`:**
  - `owner_t` enum: NONE, IMEM, DMEM_RD, DMEM_WR.
  - Constants `MEM_READ` = 0 and `MEM_WRITE` = 1.
- **Sub-module `rr_arb2`:** 2-way round-robin arbiter. Inputs are two requests; outputs are a one-hot grant and the conflict flag. It owns the pointer flop and takes the same async active-low reset.
- **Top level:** mux, owner register, response routing and counter.

## Test plan
- **Lone imem read:** imem reads `0x200` with memory holding `0xdeadbeef`, dmem idle → `imemreq_rdy` = 1 same cycle; next cycle `imemresp_val` = 1, data `0xdeadbeef`; `dmemresp_val` = 0.
- **Conflict alternation:** both ports valid for 4 cycles right after reset → grants D, I, D, I; `conflict_count` = 4; each response routed to the correct port.
- **Write then read:** dmem writes `0x1000` ← `0x12345678`, then reads `0x1000` → write ack has `dmemresp_val` = 1, rdata 0; read returns `0x12345678`.
- **Back-to-back imem:** imem reads `0x0`, `0x4`, `0x8` in consecutive cycles, dmem idle → three consecutive `imemresp_val` pulses with matching data; no bubbles.
- **Counter saturation:** with `CNT_W` = 4, 20 conflict cycles → `conflict_count` holds `0xF`.
- **Reset mid-flight:** assert `rst` = 0 the cycle after a dmem read is accepted → `dmemresp_val` = 0 immediately and stays 0 after release; counter = 0; the next conflict grants dmem.
